kernel_table_ctrl: RTL and testbench
====================================

KERNEL_TABLE_CTRL -- requirements
Module: kernel_table_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9, kernel-table index width; depth = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter CONST_POINTER_WIDTH, default 9, width of constant count and constant pointer.
REQ-003 SHALL have parameter LOCATION_INFORMATION_POINTER_WIDTH, default 9, location-info pointer width.
REQ-004 SHALL have parameter CONTEXT_POINTER_WIDTH, default 9, context pointer width.
REQ-005 SHALL have parameter CNT_WIDTH, default 16, statistics counter width.
REQ-006 SHALL define LINE_WIDTH = 2*CONST_POINTER_WIDTH + LOCATION_INFORMATION_POINTER_WIDTH + CONTEXT_POINTER_WIDTH; line packing, MSB first: {nr_of_constants, constants_pointer, locationInformation_pointer, context_pointer}.
REQ-007 clk_i  in  1  single clock; all state on rising edge.
REQ-008 rst_n_i  in  1  asynchronous, active-low reset.
REQ-009 req_valid_i / req_ready_o  in/out  1  lookup-request handshake.
REQ-010 req_addr_i  in  ADDR_WIDTH  kernel index to look up.
REQ-011 rsp_valid_o / rsp_ready_i  out/in  1  response handshake.
REQ-012 rsp_hit_o  out  1  entry was valid when read; pointer outputs SHALL be zero when 0.
REQ-013 nr_of_constants_o, constants_pointer_o  out  CONST_POINTER_WIDTH each  unpacked fields.
REQ-014 locationInformation_pointer_o  out  LOCATION_INFORMATION_POINTER_WIDTH; context_pointer_o  out  CONTEXT_POINTER_WIDTH.
REQ-015 write_memory_en_i  in  1; memory_write_addr_i  in  ADDR_WIDTH; memory_line_i  in  LINE_WIDTH  table write port.
REQ-016 invalidate_all_i  in  1  clears all entry-valid bits.
REQ-017 lookup_count_o, miss_count_o  out  CNT_WIDTH  saturating statistics.

Function
REQ-018 Output register SHALL have two states: EMPTY (rsp_valid_o=0) and FULL (rsp_valid_o=1).
REQ-019 req_ready_o SHALL equal !rsp_valid_o || rsp_ready_i (combinational, no dependence on req_valid_i).
REQ-020 A request accepted (req_valid_i && req_ready_o) at edge N SHALL present its response with rsp_valid_o=1 after edge N; latency exactly 1 cycle.
REQ-021 FULL and rsp_ready_i=0: all response outputs SHALL hold stable; later writes/invalidates SHALL NOT alter the held response.
REQ-022 FULL and rsp_ready_i=1 with new accepted request: SHALL stay FULL with new data (back-to-back, one response per cycle).
REQ-023 FULL, rsp_ready_i=1, no request: SHALL go EMPTY.
REQ-024 Write at edge N SHALL store the line and set that entry's valid bit.
REQ-025 Request and write to the same address in the same cycle: response SHALL carry the new line with rsp_hit_o=1 (write-first bypass).
REQ-026 invalidate_all_i at edge N SHALL clear all valid bits; a simultaneous write SHALL leave its entry valid; a simultaneous request to a non-written address SHALL return rsp_hit_o=0.
REQ-027 lookup_count_o SHALL increment per accepted request; miss_count_o per accepted request returning rsp_hit_o=0; both SHALL saturate at all-ones.
REQ-028 Table contents SHALL be unaffected by reset; only valid bits, state and counters are reset.

Reset
REQ-029 rst_n_i low SHALL immediately force rsp_valid_o=0, rsp_hit_o=0, all pointer outputs 0, counters 0, all valid bits 0, state EMPTY.
REQ-030 Reset mid-operation SHALL discard any held response; req_ready_o SHALL be 1 from the first edge after deassertion.

Structure
REQ-031 Package kernel_table_pkg SHALL hold default widths, LINE_WIDTH derivation function and field-offset constants.
REQ-032 Storage and valid bits SHALL live in sub-module kernel_table_mem (write port, registered read with bypass); kernel_table_ctrl holds handshake, unpack and counters.

Verification
REQ-033 Reset, write addr 5 line {3,0x10,0x20,0x30}, request 5 -> next cycle rsp_valid_o=1, rsp_hit_o=1, fields 3/0x10/0x20/0x30, lookup_count_o=1.
REQ-034 Request never-written addr 7 -> rsp_hit_o=1'b0, all pointers 0, miss_count_o=1.
REQ-035 Hold rsp_ready_i=0 for 4 cycles while writing addr 5 with new data -> outputs unchanged, req_ready_o=0; release -> old data consumed.
REQ-036 Same-cycle write addr 9 {1,2,3,4} and request 9 -> response {1,2,3,4}, hit=1.
REQ-037 invalidate_all_i plus write addr 2, then requests 2 and 5 back-to-back with rsp_ready_i=1 -> hit=1 then hit=0, one response per cycle.
REQ-038 CNT_WIDTH=4, 20 accepted requests -> lookup_count_o saturates at 15; rst_n_i pulse mid-response -> rsp_valid_o=0 immediately.

Source files
------------

// File: rtl/kernel_table_pkg.sv
// -----------------------------------------------------------------------------
// kernel_table_pkg
// Shared definitions for the kernel-table lookup controller:
//   - default parameter widths
//   - line-width derivation and field-offset helpers for the packed line
//     {nr_of_constants, constants_pointer, locationInformation_pointer,
//      context_pointer} (MSB first)
//   - response-register state encoding
// -----------------------------------------------------------------------------
package kernel_table_pkg;

    localparam int DEF_ADDR_WIDTH                         = 9;
    localparam int DEF_CONST_POINTER_WIDTH                = 9;
    localparam int DEF_LOCATION_INFORMATION_POINTER_WIDTH = 9;
    localparam int DEF_CONTEXT_POINTER_WIDTH              = 9;
    localparam int DEF_CNT_WIDTH                          = 16;

    // Total width of one table line.
    function automatic int line_width(input int cw, input int lw, input int xw);
        return 2 * cw + lw + xw;
    endfunction

    // LSB position of each field inside the packed line. The context pointer
    // occupies the bottom bits, the constant count the top bits.
    function automatic int ctx_lsb();
        return 0;
    endfunction

    function automatic int loc_lsb(input int xw);
        return xw;
    endfunction

    function automatic int cptr_lsb(input int lw, input int xw);
        return xw + lw;
    endfunction

    function automatic int nr_lsb(input int cw, input int lw, input int xw);
        return xw + lw + cw;
    endfunction

    localparam int DEF_LINE_WIDTH = line_width(DEF_CONST_POINTER_WIDTH,
                                               DEF_LOCATION_INFORMATION_POINTER_WIDTH,
                                               DEF_CONTEXT_POINTER_WIDTH);

    // Output register: EMPTY means no response presented, FULL means one is.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } rsp_state_e;

endpackage

// File: rtl/kernel_table_mem.sv
// -----------------------------------------------------------------------------
// kernel_table_mem
// Kernel-table storage with per-entry valid bits.
//   clk_i, rst_n_i         : clock, asynchronous active-low reset (valid bits
//                            and read-hit flag only; line storage is never reset)
//   wr_en_i/wr_addr_i/
//   wr_line_i              : write port; a write also sets the entry valid
//   inv_all_i              : clear every valid bit (a same-cycle write survives)
//   rd_en_i/rd_addr_i      : read request; result registered on rd_en_i only
//   lookup_hit_o           : combinational hit status of the current read address
//   rd_line_o, rd_hit_o    : registered read result, held while rd_en_i is low
// -----------------------------------------------------------------------------
module kernel_table_mem
    import kernel_table_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LINE_WIDTH = DEF_LINE_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [LINE_WIDTH-1:0] wr_line_i,
    input  logic                  inv_all_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic                  lookup_hit_o,
    output logic [LINE_WIDTH-1:0] rd_line_o,
    output logic                  rd_hit_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [LINE_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]      r_valid;
    logic [LINE_WIDTH-1:0] r_rd_line;
    logic                  r_rd_hit;

    logic                  w_bypass;
    logic                  w_lookup_hit;

    // A same-cycle write to the read address wins over the stored line.
    assign w_bypass     = wr_en_i && (wr_addr_i == rd_addr_i);
    // An invalidate in the same cycle kills the stored entry, but not a
    // bypassed write, which lands after the invalidate.
    assign w_lookup_hit = w_bypass || (r_valid[rd_addr_i] && !inv_all_i);

    // Line storage: plain RAM, no reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            r_mem[wr_addr_i] <= wr_line_i;
        end
    end

    // Registered read with read enable; the register doubles as the response
    // data holder, so it only moves when a new request is accepted.
    always_ff @(posedge clk_i) begin
        if (rd_en_i) begin
            r_rd_line <= w_bypass ? wr_line_i : r_mem[rd_addr_i];
        end
    end

    // Valid bits: invalidate first, then the write's set overrides it for its
    // own entry (last non-blocking assignment wins).
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_valid <= '0;
        end else begin
            if (inv_all_i) begin
                r_valid <= '0;
            end
            if (wr_en_i) begin
                r_valid[wr_addr_i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rd_hit <= 1'b0;
        end else if (rd_en_i) begin
            r_rd_hit <= w_lookup_hit;
        end
    end

    assign lookup_hit_o = w_lookup_hit;
    assign rd_line_o    = r_rd_line;
    assign rd_hit_o     = r_rd_hit;

endmodule

// File: rtl/kernel_table_ctrl.sv
// -----------------------------------------------------------------------------
// kernel_table_ctrl
// Kernel-table lookup controller: one-deep response register with
// valid/ready handshakes, field unpacking and saturating statistics.
//   clk_i, rst_n_i                    : clock, asynchronous active-low reset
//   req_valid_i/req_ready_o/req_addr_i: lookup request
//   rsp_valid_o/rsp_ready_i           : response handshake (1-cycle latency)
//   rsp_hit_o                         : entry valid at lookup; fields zero on miss
//   nr_of_constants_o, constants_pointer_o,
//   locationInformation_pointer_o,
//   context_pointer_o                 : unpacked line fields
//   write_memory_en_i/memory_write_addr_i/
//   memory_line_i                     : table write port
//   invalidate_all_i                  : clear all valid bits
//   lookup_count_o, miss_count_o      : saturating lookup / miss counters
// -----------------------------------------------------------------------------
module kernel_table_ctrl
    import kernel_table_pkg::*;
#(
    parameter int ADDR_WIDTH                         = DEF_ADDR_WIDTH,
    parameter int CONST_POINTER_WIDTH                = DEF_CONST_POINTER_WIDTH,
    parameter int LOCATION_INFORMATION_POINTER_WIDTH = DEF_LOCATION_INFORMATION_POINTER_WIDTH,
    parameter int CONTEXT_POINTER_WIDTH              = DEF_CONTEXT_POINTER_WIDTH,
    parameter int CNT_WIDTH                          = DEF_CNT_WIDTH,
    parameter int LINE_WIDTH = line_width(CONST_POINTER_WIDTH,
                                          LOCATION_INFORMATION_POINTER_WIDTH,
                                          CONTEXT_POINTER_WIDTH)
) (
    input  logic                                          clk_i,
    input  logic                                          rst_n_i,
    input  logic                                          req_valid_i,
    output logic                                          req_ready_o,
    input  logic [ADDR_WIDTH-1:0]                         req_addr_i,
    output logic                                          rsp_valid_o,
    input  logic                                          rsp_ready_i,
    output logic                                          rsp_hit_o,
    output logic [CONST_POINTER_WIDTH-1:0]                nr_of_constants_o,
    output logic [CONST_POINTER_WIDTH-1:0]                constants_pointer_o,
    output logic [LOCATION_INFORMATION_POINTER_WIDTH-1:0] locationInformation_pointer_o,
    output logic [CONTEXT_POINTER_WIDTH-1:0]              context_pointer_o,
    input  logic                                          write_memory_en_i,
    input  logic [ADDR_WIDTH-1:0]                         memory_write_addr_i,
    input  logic [LINE_WIDTH-1:0]                         memory_line_i,
    input  logic                                          invalidate_all_i,
    output logic [CNT_WIDTH-1:0]                          lookup_count_o,
    output logic [CNT_WIDTH-1:0]                          miss_count_o
);

    localparam int CW = CONST_POINTER_WIDTH;
    localparam int LW = LOCATION_INFORMATION_POINTER_WIDTH;
    localparam int XW = CONTEXT_POINTER_WIDTH;

    localparam int NR_LSB   = nr_lsb(CW, LW, XW);
    localparam int CPTR_LSB = cptr_lsb(LW, XW);
    localparam int LOC_LSB  = loc_lsb(XW);
    localparam int CTX_LSB  = ctx_lsb();

    rsp_state_e            r_state;
    rsp_state_e            w_state_next;
    logic [CNT_WIDTH-1:0]  r_lookup_cnt;
    logic [CNT_WIDTH-1:0]  r_miss_cnt;

    logic                  w_rsp_valid;
    logic                  w_req_ready;
    logic                  w_accept;
    logic                  w_lookup_hit;
    logic [LINE_WIDTH-1:0] w_rd_line;
    logic                  w_rd_hit;

    assign w_rsp_valid = (r_state == ST_FULL);
    // Ready depends only on the output register, never on req_valid_i.
    assign w_req_ready = !w_rsp_valid || rsp_ready_i;
    assign w_accept    = req_valid_i && w_req_ready;

    kernel_table_mem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LINE_WIDTH (LINE_WIDTH)
    ) u_mem (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .wr_en_i      (write_memory_en_i),
        .wr_addr_i    (memory_write_addr_i),
        .wr_line_i    (memory_line_i),
        .inv_all_i    (invalidate_all_i),
        .rd_en_i      (w_accept),
        .rd_addr_i    (req_addr_i),
        .lookup_hit_o (w_lookup_hit),
        .rd_line_o    (w_rd_line),
        .rd_hit_o     (w_rd_hit)
    );

    // Response register state.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_accept) begin
                    w_state_next = ST_FULL;
                end else if (rsp_ready_i) begin
                    w_state_next = ST_EMPTY;
                end
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    // Statistics update at accept time, using the combinational hit status so
    // both counters step on the same edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_lookup_cnt <= '0;
            r_miss_cnt   <= '0;
        end else if (w_accept) begin
            if (!(&r_lookup_cnt)) begin
                r_lookup_cnt <= r_lookup_cnt + 1'b1;
            end
            if (!w_lookup_hit && !(&r_miss_cnt)) begin
                r_miss_cnt <= r_miss_cnt + 1'b1;
            end
        end
    end

    // The line register has no reset; gating by the (reset) hit flag keeps the
    // fields at zero after reset and on every miss.
    assign rsp_valid_o                   = w_rsp_valid;
    assign req_ready_o                   = w_req_ready;
    assign rsp_hit_o                     = w_rd_hit;
    assign nr_of_constants_o             = w_rd_hit ? w_rd_line[NR_LSB   +: CW] : '0;
    assign constants_pointer_o           = w_rd_hit ? w_rd_line[CPTR_LSB +: CW] : '0;
    assign locationInformation_pointer_o = w_rd_hit ? w_rd_line[LOC_LSB  +: LW] : '0;
    assign context_pointer_o             = w_rd_hit ? w_rd_line[CTX_LSB  +: XW] : '0;
    assign lookup_count_o                = r_lookup_cnt;
    assign miss_count_o                  = r_miss_cnt;

endmodule

// File: tb/tb_kernel_table_ctrl.sv
// -----------------------------------------------------------------------------
// tb_kernel_table_ctrl
// Scoreboard bench: a reference table model predicts each accepted response,
// pushes it to a queue and compares it while the DUT presents it.
// -----------------------------------------------------------------------------
module tb_kernel_table_ctrl;

    localparam int AW   = 9;
    localparam int FW   = 9;
    localparam int LW   = 4 * FW;
    localparam int CNTW = 4;
    localparam int DEPTH = 1 << AW;

    logic            clk_i = 1'b0;
    logic            rst_n_i;
    logic            req_valid_i;
    logic            req_ready_o;
    logic [AW-1:0]   req_addr_i;
    logic            rsp_valid_o;
    logic            rsp_ready_i;
    logic            rsp_hit_o;
    logic [FW-1:0]   nr_of_constants_o;
    logic [FW-1:0]   constants_pointer_o;
    logic [FW-1:0]   locationInformation_pointer_o;
    logic [FW-1:0]   context_pointer_o;
    logic            write_memory_en_i;
    logic [AW-1:0]   memory_write_addr_i;
    logic [LW-1:0]   memory_line_i;
    logic            invalidate_all_i;
    logic [CNTW-1:0] lookup_count_o;
    logic [CNTW-1:0] miss_count_o;

    kernel_table_ctrl #(
        .ADDR_WIDTH                         (AW),
        .CONST_POINTER_WIDTH                (FW),
        .LOCATION_INFORMATION_POINTER_WIDTH (FW),
        .CONTEXT_POINTER_WIDTH              (FW),
        .CNT_WIDTH                          (CNTW)
    ) dut (
        .clk_i                         (clk_i),
        .rst_n_i                       (rst_n_i),
        .req_valid_i                   (req_valid_i),
        .req_ready_o                   (req_ready_o),
        .req_addr_i                    (req_addr_i),
        .rsp_valid_o                   (rsp_valid_o),
        .rsp_ready_i                   (rsp_ready_i),
        .rsp_hit_o                     (rsp_hit_o),
        .nr_of_constants_o             (nr_of_constants_o),
        .constants_pointer_o           (constants_pointer_o),
        .locationInformation_pointer_o (locationInformation_pointer_o),
        .context_pointer_o             (context_pointer_o),
        .write_memory_en_i             (write_memory_en_i),
        .memory_write_addr_i           (memory_write_addr_i),
        .memory_line_i                 (memory_line_i),
        .invalidate_all_i              (invalidate_all_i),
        .lookup_count_o                (lookup_count_o),
        .miss_count_o                  (miss_count_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model state.
    logic [LW-1:0]   m_tab   [DEPTH];
    logic            m_valid [DEPTH];
    logic            m_full;
    logic [CNTW-1:0] m_lookup;
    logic [CNTW-1:0] m_miss;
    logic [LW:0]     sb_q [$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_value(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [LW-1:0] mk_line(input int nr, input int cp, input int lp, input int xp);
        logic [FW-1:0] a, b, c, d;
        a = FW'(nr); b = FW'(cp); c = FW'(lp); d = FW'(xp);
        return {a, b, c, d};
    endfunction

    task automatic model_reset();
        m_full   = 1'b0;
        m_lookup = '0;
        m_miss   = '0;
        sb_q.delete();
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_rsp_valid"}, rsp_valid_o, 1'b0);
        check_value({tag, "_rsp_fields"},
                    {rsp_hit_o, nr_of_constants_o, constants_pointer_o,
                     locationInformation_pointer_o, context_pointer_o}, '0);
        check_value({tag, "_lookup_cnt"}, lookup_count_o, '0);
        check_value({tag, "_miss_cnt"}, miss_count_o, '0);
        check_value({tag, "_req_ready"}, req_ready_o, 1'b1);
    endtask

    // One clock cycle: drive, predict, clock, compare. Entered and left just
    // after a falling edge.
    task automatic step(input logic rv, input logic [AW-1:0] ra, input logic rr,
                        input logic we, input logic [AW-1:0] wa, input logic [LW-1:0] wl,
                        input logic inv);
        logic ready_m, accept, hit;
        logic [LW-1:0] line;
        req_valid_i         = rv;
        req_addr_i          = ra;
        rsp_ready_i         = rr;
        write_memory_en_i   = we;
        memory_write_addr_i = wa;
        memory_line_i       = wl;
        invalidate_all_i    = inv;
        #1;
        ready_m = !m_full || rr;
        accept  = rv && ready_m;
        check_value("req_ready", req_ready_o, ready_m);
        if (m_full && rr) begin
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end
        if (accept) begin
            if (we && wa == ra) begin
                hit  = 1'b1;
                line = wl;
            end else begin
                hit  = m_valid[ra] && !inv;
                line = m_tab[ra];
            end
            sb_q.push_back(hit ? {1'b1, line} : '0);
            if (!(&m_lookup)) m_lookup = m_lookup + 1'b1;
            if (!hit && !(&m_miss)) m_miss = m_miss + 1'b1;
            $display("req addr=%0d hit=%0b line=0x%0h", ra, hit, hit ? line : '0);
        end
        m_full = accept ? 1'b1 : (rr ? 1'b0 : m_full);
        if (inv) for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        if (we) begin
            m_tab[wa]   = wl;
            m_valid[wa] = 1'b1;
        end
        @(posedge clk_i);
        #1;
        check_value("rsp_valid", rsp_valid_o, m_full);
        if (m_full) begin
            if (sb_q.size() == 0) begin
                check_value("sb_nonempty", 0, 1);
            end else begin
                check_value("rsp_data",
                            {rsp_hit_o, nr_of_constants_o, constants_pointer_o,
                             locationInformation_pointer_o, context_pointer_o}, sb_q[0]);
            end
        end
        check_value("lookup_cnt", lookup_count_o, m_lookup);
        check_value("miss_cnt", miss_count_o, m_miss);
        @(negedge clk_i);
    endtask

    initial begin
        rst_n_i             = 1'b0;
        req_valid_i         = 1'b0;
        req_addr_i          = '0;
        rsp_ready_i         = 1'b0;
        write_memory_en_i   = 1'b0;
        memory_write_addr_i = '0;
        memory_line_i       = '0;
        invalidate_all_i    = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_tab[i] = '0;
        model_reset();

        #12;
        check_reset_outputs("reset");
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Write addr 5, then look it up.
        step(0, 0, 1, 1, 5, mk_line(3, 'h10, 'h20, 'h30), 0);
        step(1, 5, 1, 0, 0, '0, 0);
        step(0, 0, 1, 0, 0, '0, 0);
        // Never-written address misses.
        step(1, 7, 1, 0, 0, '0, 0);
        step(0, 0, 1, 0, 0, '0, 0);

        // Backpressure: hold 4 cycles while rewriting addr 5, then release.
        step(1, 5, 0, 0, 0, '0, 0);
        for (int i = 0; i < 4; i++) step(1, 5, 0, 1, 5, mk_line(7, 'h1AA, 'h155, i), 0);
        step(0, 0, 1, 0, 0, '0, 0);
        step(1, 5, 1, 0, 0, '0, 0);

        // Same-cycle write and request: write-first bypass.
        step(1, 9, 1, 1, 9, mk_line(1, 2, 3, 4), 0);
        step(0, 0, 1, 0, 0, '0, 0);

        // Invalidate with write to 2, then requests 2 and 5 back-to-back.
        step(0, 0, 1, 1, 2, mk_line(8, 'h1FF, 0, 'h101), 1);
        step(1, 2, 1, 0, 0, '0, 0);
        step(1, 5, 1, 0, 0, '0, 0);
        step(0, 0, 1, 0, 0, '0, 0);
        // Invalidate alongside a request to a different, previously valid address.
        step(0, 0, 1, 1, 9, mk_line(5, 6, 7, 8), 0);
        step(1, 9, 1, 1, 3, mk_line(9, 9, 9, 9), 1);
        step(0, 0, 1, 0, 0, '0, 0);

        // Mixed traffic to push the 4-bit counters into saturation.
        for (int i = 0; i < 24; i++) begin
            step(1, AW'($urandom_range(0, 15)), (i % 3) != 0,
                 (i % 4) == 0, AW'($urandom_range(0, 15)),
                 LW'({$urandom, $urandom}), i == 11);
        end
        step(0, 0, 1, 0, 0, '0, 0);

        // Reset pulse while a response is held.
        step(1, 2, 0, 0, 0, '0, 0);
        #2;
        rst_n_i = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("midreset");
        @(negedge clk_i);
        rst_n_i = 1'b1;
        // Table survives, but every entry reads as invalid.
        step(1, 5, 1, 0, 0, '0, 0);
        step(0, 0, 1, 1, 5, mk_line(2, 'h44, 'h55, 'h66), 0);
        step(1, 5, 1, 0, 0, '0, 0);
        step(0, 0, 1, 0, 0, '0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
